pipe_barrel_shift: RTL and testbench

PIPE_BARREL_SHIFT -- requirements
Module: pipe_barrel_shift

---
 rtl/pipe_barrel_shift.sv | 162 ++++++++++++++++
 tb/tb_pipe_barrel_shift.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_barrel_shift.sv
// pipe_barrel_shift: pipelined barrel shifter / rotator, one log2 stage per cycle.
// Latency SHAMT_W enabled cycles; one result per cycle; the whole pipe stalls when out_valid && !out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_shamt/in_mode/in_tag request side;
//        out_valid/out_ready/out_data/out_tag result side; out_zero only with BARREL_ZFLAG_EN defined.
// Modes: 000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, 101-111 pass-through.
module pipe_barrel_shift #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_shamt,
  input  logic [2:0]                 in_mode,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [TAG_W-1:0]           out_tag
`ifdef BARREL_ZFLAG_EN
  ,
  output logic                       out_zero
`endif
);

  localparam int SHAMT_W = $clog2(WIDTH);

  // One shift stage: move by 2^k when the stage's shamt bit is set.
  // For SRA the MSB of the partially shifted word is still the original sign bit,
  // so each stage can replicate its own MSB.
  function automatic logic [WIDTH-1:0] stage_op(input logic [WIDTH-1:0] d,
                                                input logic [2:0]       m,
                                                input logic             b,
                                                input int               k);
    int n;
    logic [WIDTH-1:0] r;
    n = 1 << k;
    r = d;
    if (b) begin
      case (m)
        3'b000:  r = (d << n) | (d >> (WIDTH - n));
        3'b001:  r = (d >> n) | (d << (WIDTH - n));
        3'b010:  r = d << n;
        3'b011:  r = d >> n;
        3'b100:  r = WIDTH'($signed(d) >>> n);
        default: r = d;
      endcase
    end
    return r;
  endfunction

  logic                 en;
  logic                 accept;

  logic [SHAMT_W-1:0]   vld_q, vld_d;
  logic [WIDTH-1:0]     dat_q  [SHAMT_W];
  logic [WIDTH-1:0]     dat_d  [SHAMT_W];
  logic [SHAMT_W-1:0]   sh_q   [SHAMT_W];
  logic [SHAMT_W-1:0]   sh_d   [SHAMT_W];
  logic [2:0]           mode_q [SHAMT_W];
  logic [2:0]           mode_d [SHAMT_W];
  logic [TAG_W-1:0]     tag_q  [SHAMT_W];
  logic [TAG_W-1:0]     tag_d  [SHAMT_W];

  assign out_valid = vld_q[SHAMT_W-1];
  assign en        = out_ready || !out_valid;
  assign in_ready  = en && !rst;
  assign accept    = in_valid && in_ready;
  assign out_data  = dat_q[SHAMT_W-1];
  assign out_tag   = tag_q[SHAMT_W-1];

  always_comb begin
    logic [WIDTH-1:0]   s_dat;
    logic [SHAMT_W-1:0] s_sh;
    logic [2:0]         s_mode;
    logic [TAG_W-1:0]   s_tag;
    logic               s_vld;

    s_dat  = '0;
    s_sh   = '0;
    s_mode = '0;
    s_tag  = '0;
    s_vld  = 1'b0;
    vld_d  = vld_q;
    for (int k = 0; k < SHAMT_W; k++) begin
      dat_d[k]  = dat_q[k];
      sh_d[k]   = sh_q[k];
      mode_d[k] = mode_q[k];
      tag_d[k]  = tag_q[k];
    end

    if (en) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        if (k == 0) begin
          // Bubbles enter as all-zero so an idle pipe drains to zero outputs.
          s_vld  = accept;
          s_dat  = accept ? in_data  : '0;
          s_sh   = accept ? in_shamt : '0;
          s_mode = accept ? in_mode  : '0;
          s_tag  = accept ? in_tag   : '0;
        end else begin
          s_vld  = vld_q[k-1];
          s_dat  = dat_q[k-1];
          s_sh   = sh_q[k-1];
          s_mode = mode_q[k-1];
          s_tag  = tag_q[k-1];
        end
        vld_d[k]  = s_vld;
        dat_d[k]  = stage_op(s_dat, s_mode, s_sh[k], k);
        sh_d[k]   = s_sh;
        mode_d[k] = s_mode;
        tag_d[k]  = s_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < SHAMT_W; k++) begin
        dat_q[k]  <= '0;
        sh_q[k]   <= '0;
        mode_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < SHAMT_W; k++) begin
        dat_q[k]  <= dat_d[k];
        sh_q[k]   <= sh_d[k];
        mode_q[k] <= mode_d[k];
        tag_q[k]  <= tag_d[k];
      end
    end
  end

`ifdef BARREL_ZFLAG_EN
  // Zero flag is taken from the final stage result and registered alongside it,
  // so it stays aligned with out_data through stalls. Reset data is zero, hence flag 1.
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (en) begin
      zero_d = (dat_d[SHAMT_W-1] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_pipe_barrel_shift.sv
module tb_pipe_barrel_shift;
  localparam int W  = 32;
  localparam int TW = 4;
  localparam int SW = 5;
  localparam int L  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [2:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
`ifdef BARREL_ZFLAG_EN
  logic          out_zero;
`endif

  always #5 clk = ~clk;

  pipe_barrel_shift #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
`ifdef BARREL_ZFLAG_EN
    ,
    .out_zero (out_zero)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: bit-index definition of each operation, no staging.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input logic [2:0] m);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < W; i++) begin
      case (m)
        3'd0: r[(i + s) % W] = d[i];
        3'd1: r[i] = d[(i + s) % W];
        3'd2: r[i] = (i >= s) ? d[i - s] : 1'b0;
        3'd3: r[i] = (i + s < W) ? d[i + s] : 1'b0;
        3'd4: r[i] = (i + s < W) ? d[i + s] : d[W-1];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  // Scoreboard / protocol monitor, sampled on the falling edge.
  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    int            stamp;
  } exp_t;
  exp_t          sb[$];
  int            en_cnt = 0;
  int            out_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [W-1:0]  stall_d;
  logic [TW-1:0] stall_t;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      stall_prev = 1'b0;
      chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
    end else begin
      if (stall_prev) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", out_data, stall_d);
        chk("stall_tag", {28'd0, out_tag}, {28'd0, stall_t});
      end
      if (out_valid && !out_ready)
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_tag", {28'd0, out_tag}, {28'd0, e.t});
          chk("sb_latency", en_cnt - e.stamp, L);
`ifdef BARREL_ZFLAG_EN
          chk("sb_zero", {31'd0, out_zero}, {31'd0, (e.d == 0)});
`endif
        end
      end
      if (in_valid && in_ready) begin
        e.d = ref_shift(in_data, int'(in_shamt), in_mode);
        e.t = in_tag;
        e.stamp = en_cnt;
        sb.push_back(e);
      end
      stall_prev = out_valid && !out_ready;
      stall_d = out_data;
      stall_t = out_tag;
      if (out_ready || !out_valid) en_cnt++;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [2:0] m,
                      input logic [TW-1:0] t);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_mode  = m;
    in_tag   = t;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  typedef struct {
    logic [2:0]    mode;
    logic [W-1:0]  data;
    logic [SW-1:0] shamt;
    logic [TW-1:0] tag;
    logic [W-1:0]  exp_data;
  } vec_t;
  vec_t vecs[14];

  task automatic run_vec(input vec_t v);
    int cnt;
    send(v.data, v.shamt, v.mode, v.tag);
    in_valid = 1'b0;
    cnt = 0;
    // Accept edge already passed; L-1 further edges bring it to the output.
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("vec_latency", cnt, L - 1);
    chk("vec_data", out_data, v.exp_data);
    chk("vec_tag", {28'd0, out_tag}, {28'd0, v.tag});
`ifdef BARREL_ZFLAG_EN
    chk("vec_zero", {31'd0, out_zero}, {31'd0, (v.exp_data == 0)});
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    vecs[0]  = '{3'd0, 32'h80000001, 5'd1,  4'd3, 32'h00000003};
    vecs[1]  = '{3'd4, 32'h80000000, 5'd31, 4'd1, 32'hFFFFFFFF};
    vecs[2]  = '{3'd3, 32'h80000000, 5'd31, 4'd2, 32'h00000001};
    vecs[3]  = '{3'd1, 32'h00000001, 5'd4,  4'd4, 32'h10000000};
    vecs[4]  = '{3'd2, 32'h80000000, 5'd1,  4'd5, 32'h00000000};
    vecs[5]  = '{3'd0, 32'h80000000, 5'd1,  4'd6, 32'h00000001};
    vecs[6]  = '{3'd6, 32'hDEADBEEF, 5'd7,  4'd7, 32'hDEADBEEF};
    vecs[7]  = '{3'd2, 32'h0000000F, 5'd4,  4'd8, 32'h000000F0};
    vecs[8]  = '{3'd1, 32'h12345678, 5'd0,  4'd9, 32'h12345678};
    vecs[9]  = '{3'd4, 32'h7FFFFFFF, 5'd30, 4'hA, 32'h00000001};
    vecs[10] = '{3'd0, 32'h12345678, 5'd8,  4'hB, 32'h34567812};
    vecs[11] = '{3'd3, 32'hF0000000, 5'd28, 4'hC, 32'h0000000F};
    vecs[12] = '{3'd7, 32'hA5A5A5A5, 5'd31, 4'hD, 32'hA5A5A5A5};
    vecs[13] = '{3'd1, 32'h12345678, 5'd31, 4'hE, 32'h2468ACF0};

    // Reset, with a request offered that must not be taken.
    in_valid = 1'b1;
    in_data  = 32'hCAFEF00D;
    in_tag   = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
`ifdef BARREL_ZFLAG_EN
    chk("rst_out_zero", {31'd0, out_zero}, 32'd1);
`endif
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // Directed vectors.
    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Eight back-to-back requests with a four-cycle consumer stall.
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 4'(i));
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("b2b_count", out_cnt - base, 8);

    // Reset with three requests in flight.
    base = out_cnt;
    send(32'h11111111, 5'd1, 3'd0, 4'h1);
    send(32'h22222222, 5'd2, 3'd1, 4'h2);
    send(32'h33333333, 5'd3, 3'd2, 4'h3);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_out_tag", {28'd0, out_tag}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_emerge", {31'd0, out_valid}, 32'd0);
    end
    chk("midrst_count", out_cnt - base, 0);

    // Random traffic with random backpressure against the reference model.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_shamt  = 5'($urandom_range(0, 31));
      in_mode   = 3'($urandom_range(0, 7));
      in_tag    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Full-rate stream: one result per cycle with out_ready high.
    base = out_cnt;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_shamt = 5'($urandom_range(0, 31));
      in_mode  = 3'($urandom_range(0, 7));
      in_tag   = 4'(i);
      @(negedge clk);
      if (in_ready) n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("stream_accepts", n, 20);
    drain();
    chk("stream_count", out_cnt - base, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
